// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave: decodes NUM_SLAVES 1 KiWord regions, a read-only
// window at the bottom of each region, programmable wait states, and the
// two-cycle ERROR response for out-of-range accesses and ROM writes.
// Optional build macro: AHB_SLV_SEQ_FASTPATH_EN (SEQ beats of incrementing
// bursts complete with zero wait states).
module ahb_lite_mem_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int NUM_SLAVES  = 2,
    parameter int ROM_WORDS   = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              reset,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic              HREADY,
    input  logic [DATA_W-1:0] HWDATA,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP
);

    localparam int MEM_DEPTH = NUM_SLAVES * 1024;
    localparam int MEM_AW    = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
    // Source of HRDATA: zero (reset/errored read), side register (ROM word or
    // forwarded write data), or the registered RAM read port.
    typedef enum logic [1:0] {RD_ZERO, RD_AUX, RD_MEM} rd_sel_t;

    state_t              state_q, state_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic                dp_q, dp_d;          // OKAY data phase outstanding
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    rd_sel_t             rd_sel_q, rd_sel_d;
    logic [DATA_W-1:0]   aux_q, aux_d;
    logic [DATA_W-1:0]   mem_rd_q;
    logic [DATA_W-1:0]   mem [MEM_DEPTH];

    logic                slave_ready;
    logic                capture;
    logic                out_of_range;
    logic                rom_hit;
    logic                addr_err;
    logic                zero_wait_beat;
    logic                complete;
    logic                commit;
    logic                rd_fetch;
    logic                fwd_hit;
    logic [MEM_AW-1:0]   haddr_idx;
    logic [DATA_W-1:0]   rom_word;
    logic                unused_inputs;

    // Address phase is only accepted while this slave is showing ready, so
    // bus changes during wait/error-first cycles are never sampled.
    assign slave_ready  = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign capture      = HSEL & HREADY & HTRANS[1] & slave_ready;
    assign out_of_range = (HADDR >= ADDR_W'(MEM_DEPTH));
    assign rom_hit      = (HADDR[9:0] < 10'(ROM_WORDS));
    assign addr_err     = out_of_range | (HWRITE & rom_hit);
    assign haddr_idx    = HADDR[MEM_AW-1:0];
    // ROM contents are the constant {region, index}; writes to them always
    // error, so the value never needs storage.
    assign rom_word     = (DATA_W'(HADDR >> 10) << 16) | DATA_W'(HADDR[9:0]);

`ifdef AHB_SLV_SEQ_FASTPATH_EN
    assign zero_wait_beat = (WAIT_STATES == 0) ||
                            ((HTRANS == 2'b11) && HBURST[0] && (HBURST != 3'b001));
    assign unused_inputs  = ^HSIZE;
`else
    assign zero_wait_beat = (WAIT_STATES == 0);
    assign unused_inputs  = ^{HSIZE, HBURST, HTRANS[0]};
`endif

    // Every OKAY data phase completes in IDLE (waits return there first).
    assign complete = (state_q == ST_IDLE) & dp_q;
    assign commit   = complete & write_q;
    assign rd_fetch = capture & ~HWRITE;
    assign fwd_hit  = commit & (addr_q == haddr_idx);

    // Next-state, transfer bookkeeping and read-source selection
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        dp_d       = dp_q;
        addr_d     = addr_q;
        write_d    = write_q;
        rd_sel_d   = rd_sel_q;
        aux_d      = aux_q;

        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (complete) begin
                    dp_d = 1'b0;
                end
                state_d = ST_IDLE;
                if (capture) begin
                    addr_d  = haddr_idx;
                    write_d = HWRITE;
                    if (addr_err) begin
                        dp_d    = 1'b0;
                        state_d = ST_ERR1;
                    end else begin
                        dp_d = 1'b1;
                        if (!zero_wait_beat) begin
                            state_d    = ST_WAIT;
                            wait_cnt_d = WAIT_LOAD;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Read data is fetched on the capture edge and held until the next read.
        if (rd_fetch) begin
            if (addr_err) begin
                rd_sel_d = RD_ZERO;
            end else if (rom_hit) begin
                rd_sel_d = RD_AUX;
                aux_d    = rom_word;
            end else if (fwd_hit) begin
                rd_sel_d = RD_AUX;
                aux_d    = HWDATA;
            end else begin
                rd_sel_d = RD_MEM;
            end
        end
    end

    // Control state registers
    always_ff @(posedge HCLK) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            dp_q       <= 1'b0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            rd_sel_q   <= RD_ZERO;
            aux_q      <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            dp_q       <= dp_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            rd_sel_q   <= rd_sel_d;
            aux_q      <= aux_d;
        end
    end

    // RAM array: write on data-phase completion, registered read on capture
    always_ff @(posedge HCLK) begin
        if (commit && !reset) begin
            mem[addr_q] <= HWDATA;
        end
        if (rd_fetch) begin
            mem_rd_q <= mem[haddr_idx];
        end
    end

    // Response outputs decoded from state
    always_comb begin
        HREADYOUT = (state_q != ST_WAIT) && (state_q != ST_ERR1);
        HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
        case (rd_sel_q)
            RD_MEM:  HRDATA = mem_rd_q;
            RD_AUX:  HRDATA = aux_q;
            default: HRDATA = '0;
        endcase
    end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave: three instances (0, 3 and 2 wait states)
// share one bus; only the instance chosen by dsel is selected at a time.
module tb_ahb_lite_mem_slave;

    logic        HCLK = 1'b0;
    logic        reset;
    logic        hsel_bus;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [2:0]  rdy_v;
    logic [2:0]  resp_v;
    logic [31:0] rdata_v [3];
    int          dsel;

    always #5 HCLK = ~HCLK;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        logic hsel_i;
        assign hsel_i = hsel_bus && (dsel == gi);
        ahb_lite_mem_slave #(
            .DATA_W(32), .ADDR_W(32), .NUM_SLAVES(2), .ROM_WORDS(4),
            .WAIT_STATES((gi == 0) ? 0 : ((gi == 1) ? 3 : 2))
        ) u_dut (
            .HCLK(HCLK), .reset(reset), .HSEL(hsel_i), .HADDR(HADDR),
            .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
            .HREADY(rdy_v[gi]), .HWDATA(HWDATA), .HRDATA(rdata_v[gi]),
            .HREADYOUT(rdy_v[gi]), .HRESP(resp_v[gi])
        );
    end

    typedef struct {
        string       tag;
        logic        wr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rd;
        int          waits;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [int];
    int          compared   = 0;
    int          mismatched = 0;
    int          low_cnt    = 0;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000, B_INCR = 3'b001, B_INCR4 = 3'b011;

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: check the data phase at the falling edge, present the
    // next address phase (junk while the slave stalls), push on acceptance.
    task automatic tick(input logic [1:0] tr, input logic wr, input logic [31:0] addr,
                        input logic [2:0] burst, input exp_t ex, output logic took);
        logic        rdy;
        logic        resp;
        logic [31:0] rd;
        exp_t        e;
        logic        popped_wr;
        logic [31:0] popped_wd;
        popped_wr = 1'b0;
        popped_wd = 32'h0;
        @(negedge HCLK);
        rdy  = rdy_v[dsel];
        resp = resp_v[dsel];
        rd   = rdata_v[dsel];
        if (sb.size() != 0) begin
            if (!rdy) begin
                low_cnt++;
                chk({sb[0].tag, "/resp_wait"}, 32'(resp), 32'(sb[0].err));
            end else begin
                e = sb.pop_front();
                chk({e.tag, "/resp"}, 32'(resp), 32'(e.err));
                chk({e.tag, "/waits"}, low_cnt, e.waits);
                if (!e.wr) chk({e.tag, "/rdata"}, rd, e.rd);
                $display("txn %s wr=%0b resp=%0b waits=%0d rdata=%h", e.tag, e.wr, resp, low_cnt, rd);
                popped_wr = e.wr && !e.err;
                popped_wd = e.wdata;
                low_cnt   = 0;
            end
        end else begin
            chk("idle/ready", 32'(rdy), 32'd1);
            chk("idle/resp", 32'(resp), 32'd0);
        end
        if (rdy) begin
            hsel_bus = 1'b1;
            HTRANS   = tr;
            HWRITE   = wr;
            HADDR    = addr;
            HBURST   = burst;
            HWDATA   = popped_wr ? popped_wd : $urandom;
        end else begin
            HADDR  = $urandom;
            HWRITE = 1'($urandom);
            HWDATA = $urandom;
        end
        took = rdy;
        @(posedge HCLK);
        if (rdy && tr[1]) sb.push_back(ex);
        #1;
    endtask

    task automatic issue(input string tag, input logic [1:0] tr, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] burst);
        exp_t ex;
        logic took;
        logic fast;
        int   key;
        key  = dsel * 65536 + int'(addr);
        fast = 1'b0;
`ifdef AHB_SLV_SEQ_FASTPATH_EN
        fast = (tr == T_SEQ) && burst[0] && (burst != B_INCR);
`endif
        ex.tag   = tag;
        ex.wr    = wr;
        ex.wdata = wd;
        ex.err   = (addr >= 32'd2048) || (wr && (addr[9:0] < 10'd4));
        ex.waits = ex.err ? 1 : (fast ? 0 : ws_of(dsel));
        if (ex.err)                 ex.rd = 32'h0;
        else if (addr[9:0] < 10'd4) ex.rd = ((addr >> 10) << 16) | (addr & 32'h3FF);
        else if (mdl.exists(key))   ex.rd = mdl[key];
        else                        ex.rd = 'x;
        if (!ex.err && wr && tr[1]) mdl[key] = wd;
        took = 1'b0;
        for (int n = 0; n < 40 && !took; n++) tick(tr, wr, addr, burst, ex, took);
        chk({tag, "/accept"}, 32'(took), 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) issue("idle", T_IDLE, 1'b0, 32'h0, 32'h0, B_SINGLE);
        chk("drain/empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; hsel_bus = 1'b0; HTRANS = T_IDLE; HWRITE = 1'b0;
        HADDR = 32'h0; HWDATA = 32'h0; HSIZE = 3'b010; HBURST = B_SINGLE; dsel = 0;
        repeat (3) @(posedge HCLK);
        #1 reset = 1'b0;

        // Reset state on every instance
        @(negedge HCLK);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset%0d/hreadyout", d), 32'(rdy_v[d]), 32'd1);
            chk($sformatf("reset%0d/hresp", d), 32'(resp_v[d]), 32'd0);
            chk($sformatf("reset%0d/hrdata", d), rdata_v[d], 32'h0);
        end

        // Reset in the 2nd wait cycle of a 3-wait read
        dsel = 1;
        @(posedge HCLK); #1;
        hsel_bus = 1'b1; HTRANS = T_NSEQ; HADDR = 32'd2; HWRITE = 1'b0;
        @(posedge HCLK); #1;
        HTRANS = T_IDLE;
        @(negedge HCLK);
        chk("rst_mid_wait/wait1", 32'(rdy_v[1]), 32'd0);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("rst_mid_wait/wait2", 32'(rdy_v[1]), 32'd0);
        reset = 1'b1;
        @(posedge HCLK); #1;
        reset = 1'b0;
        @(negedge HCLK);
        chk("rst_mid_wait/hreadyout", 32'(rdy_v[1]), 32'd1);
        chk("rst_mid_wait/hresp", 32'(resp_v[1]), 32'd0);
        chk("rst_mid_wait/hrdata", rdata_v[1], 32'h0);
        sb.delete();
        low_cnt = 0;
        issue("ws3_rd2", T_NSEQ, 1'b0, 32'd2, 32'h0, B_SINGLE);
        drain();

        // Zero-wait write then back-to-back read (forwarding), ROM and range edges
        dsel = 0;
        issue("wr010", T_NSEQ, 1'b1, 32'h010, 32'hDEADBEEF, B_SINGLE);
        issue("rd010_fwd", T_NSEQ, 1'b0, 32'h010, 32'h0, B_SINGLE);
        issue("wr402_rom", T_NSEQ, 1'b1, 32'h402, 32'h12345678, B_SINGLE);
        issue("rd402", T_NSEQ, 1'b0, 32'h402, 32'h0, B_SINGLE);
        issue("wr003_rom", T_NSEQ, 1'b1, 32'h003, 32'h33333333, B_SINGLE);
        issue("wr004", T_NSEQ, 1'b1, 32'h004, 32'hA5A50004, B_SINGLE);
        issue("rd003", T_NSEQ, 1'b0, 32'h003, 32'h0, B_SINGLE);
        issue("rd004", T_NSEQ, 1'b0, 32'h004, 32'h0, B_SINGLE);
        issue("rd2048", T_NSEQ, 1'b0, 32'd2048, 32'h0, B_SINGLE);
        issue("wr2047", T_NSEQ, 1'b1, 32'd2047, 32'h7FF07FF0, B_SINGLE);
        issue("wr810_oor", T_NSEQ, 1'b1, 32'h810, 32'hBAADF00D, B_SINGLE);
        issue("rd2047", T_NSEQ, 1'b0, 32'd2047, 32'h0, B_SINGLE);
        issue("rd010_mem", T_NSEQ, 1'b0, 32'h010, 32'h0, B_SINGLE);
        drain();

        // INCR4 write burst with 2 wait states, then read back
        dsel = 2;
        issue("b4_w20", T_NSEQ, 1'b1, 32'h020, 32'h11110020, B_INCR4);
        issue("b4_w21", T_SEQ, 1'b1, 32'h021, 32'h22220021, B_INCR4);
        issue("b4_w22", T_SEQ, 1'b1, 32'h022, 32'h33330022, B_INCR4);
        issue("b4_w23", T_SEQ, 1'b1, 32'h023, 32'h44440023, B_INCR4);
        for (int i = 0; i < 4; i++)
            issue($sformatf("b4_r%0d", i), T_NSEQ, 1'b0, 32'h020 + 32'(i), 32'h0, B_SINGLE);
        drain();

        // IDLE and BUSY interleaved in an INCR burst must not touch memory
        issue("w40", T_NSEQ, 1'b1, 32'h040, 32'h0BAD0040, B_SINGLE);
        issue("inc_w30", T_NSEQ, 1'b1, 32'h030, 32'hC0DE0030, B_INCR);
        issue("inc_busy", T_BUSY, 1'b1, 32'h040, 32'h0, B_INCR);
        issue("inc_w31", T_SEQ, 1'b1, 32'h031, 32'hC0DE0031, B_INCR);
        issue("inc_idle", T_IDLE, 1'b1, 32'h040, 32'h0, B_INCR);
        issue("inc_w32", T_SEQ, 1'b1, 32'h032, 32'hC0DE0032, B_INCR);
        issue("rd030", T_NSEQ, 1'b0, 32'h030, 32'h0, B_SINGLE);
        issue("rd031", T_NSEQ, 1'b0, 32'h031, 32'h0, B_SINGLE);
        issue("rd032", T_NSEQ, 1'b0, 32'h032, 32'h0, B_SINGLE);
        issue("rd040", T_NSEQ, 1'b0, 32'h040, 32'h0, B_SINGLE);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
